// File: rtl/bus_pkg.sv
// Shared types and helpers for the memory-bus initiator.
package bus_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_SETUP,
    RD_STROBE,
    MERGE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RESP,
    ERR
  } state_t;

  // Only the two low address bits matter for alignment; size 3 is never legal.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] addr);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_B:    bad = 1'b0;
      SZ_H:    bad = addr[0];
      SZ_W:    bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/bus_lane.sv
// Byte-lane logic: sign/zero extension of loaded data and sub-word store merge.
module bus_lane (
  input  logic [31:0] rd_word,
  input  logic [31:0] wr_data,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);
  import bus_pkg::*;

  // Extend the low lane of the read word to 32 bits.
  always_comb begin
    case (size)
      SZ_B:    load_data = {{24{rd_word[7] & ~is_unsigned}}, rd_word[7:0]};
      SZ_H:    load_data = {{16{rd_word[15] & ~is_unsigned}}, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
  end

  // Overlay the store data on the low lane(s); upper lanes keep the read value.
  always_comb begin
    case (size)
      SZ_B:    merge_data = {rd_word[31:8], wr_data[7:0]};
      SZ_H:    merge_data = {rd_word[31:16], wr_data[15:0]};
      default: merge_data = wr_data;
    endcase
  end

endmodule

// File: rtl/bus_initiator.sv
// Memory-bus initiator: single load/store requests to addr/data/strobe
// sequences on a shared tri-state bus. Sub-word stores are read-modify-write
// because the responder always moves a full 4-byte word.
module bus_initiator #(
  parameter int STROBE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] bus_addr,
  inout  wire  [31:0] bus_data,
  output logic        bus_read,
  output logic        bus_write
);
  import bus_pkg::*;

  localparam int CW = $clog2(STROBE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STROBE_CYCLES - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0]   addr_reg, data_reg, wdata_reg;
  logic [1:0]    size_reg;
  logic          write_reg, unsigned_reg;
  logic [31:0]   load_data, merge_data;
  logic          strobe_done;
  logic          drive;

  assign strobe_done = (cnt_reg == CNT_LAST);

  // data_reg holds the sampled read word, later the merged/store word.
  bus_lane u_lane (
    .rd_word     (data_reg),
    .wr_data     (wdata_reg),
    .size        (size_reg),
    .is_unsigned (unsigned_reg),
    .load_data   (load_data),
    .merge_data  (merge_data)
  );

  // State register and strobe-length counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    req_ready  = 1'b0;
    bus_read   = 1'b0;
    bus_write  = 1'b0;
    drive      = 1'b0;
    rsp_valid  = 1'b0;
    rsp_err    = 1'b0;
    rsp_rdata  = '0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (misaligned(req_size, req_addr[1:0]))
            state_next = ERR;
          else if (req_write && req_size == SZ_W)
            state_next = WR_SETUP;
          else
            state_next = RD_SETUP;
        end
      end
      RD_SETUP: state_next = RD_STROBE;
      RD_STROBE: begin
        bus_read = 1'b1;
        if (strobe_done)
          state_next = write_reg ? MERGE : RESP;
        else
          cnt_next = cnt_reg + CW'(1);
      end
      MERGE: state_next = WR_SETUP;
      WR_SETUP: begin
        drive      = 1'b1;
        state_next = WR_STROBE;
      end
      WR_STROBE: begin
        drive     = 1'b1;
        bus_write = 1'b1;
        if (strobe_done)
          state_next = WR_HOLD;
        else
          cnt_next = cnt_reg + CW'(1);
      end
      WR_HOLD: begin
        drive      = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        rsp_valid  = 1'b1;
        rsp_rdata  = write_reg ? 32'd0 : load_data;
        state_next = IDLE;
      end
      ERR: begin
        rsp_valid  = 1'b1;
        rsp_err    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Request capture, read-data sampling on the last strobe edge, lane merge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_reg     <= '0;
      data_reg     <= '0;
      wdata_reg    <= '0;
      size_reg     <= '0;
      write_reg    <= 1'b0;
      unsigned_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            size_reg     <= req_size;
            write_reg    <= req_write;
            unsigned_reg <= req_unsigned;
            wdata_reg    <= req_wdata;
            data_reg     <= req_wdata;
            // Rejected requests never reach the bus, so the address stays put.
            if (!misaligned(req_size, req_addr[1:0]))
              addr_reg <= req_addr;
          end
        end
        RD_STROBE: if (strobe_done) data_reg <= bus_data;
        MERGE:     data_reg <= merge_data;
        default:   ;
      endcase
    end
  end

  assign bus_addr = addr_reg;
  assign bus_data = drive ? data_reg : 32'bz;

endmodule

// File: tb/tb_bus_initiator.sv
// Directed bench for bus_initiator: two instances (1- and 3-cycle strobes),
// each with a small byte-addressed memory model on its tri-state bus.
module tb_bus_initiator;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid1 = 1'b0, req_valid3 = 1'b0;
  logic        req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;

  logic        req_ready1, rsp_valid1, rsp_err1, bus_read1, bus_write1;
  logic [31:0] rsp_rdata1, bus_addr1;
  wire  [31:0] bus_data1;
  logic        req_ready3, rsp_valid3, rsp_err3, bus_read3, bus_write3;
  logic [31:0] rsp_rdata3, bus_addr3;
  wire  [31:0] bus_data3;

  bus_initiator #(.STROBE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid1),
    .rsp_rdata(rsp_rdata1), .rsp_err(rsp_err1), .bus_addr(bus_addr1),
    .bus_data(bus_data1), .bus_read(bus_read1), .bus_write(bus_write1)
  );

  bus_initiator #(.STROBE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid3), .req_ready(req_ready3),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3), .bus_addr(bus_addr3),
    .bus_data(bus_data3), .bus_read(bus_read3), .bus_write(bus_write3)
  );

  // Memory models: 4 bytes little-endian from bus_addr, plus a backdoor loader.
  logic [7:0]  mem1 [0:4095];
  logic [7:0]  mem3 [0:4095];
  logic        bd_we = 1'b0, bd_sel = 1'b0;
  logic [11:0] bd_addr = 12'd0;
  logic [7:0]  bd_byte = 8'd0;

  wire [11:0] a1 = bus_addr1[11:0];
  wire [11:0] a3 = bus_addr3[11:0];
  wire [31:0] mw1 = {mem1[a1 + 12'd3], mem1[a1 + 12'd2], mem1[a1 + 12'd1], mem1[a1]};
  wire [31:0] mw3 = {mem3[a3 + 12'd3], mem3[a3 + 12'd2], mem3[a3 + 12'd1], mem3[a3]};
  assign bus_data1 = bus_read1 ? mw1 : 32'bz;
  assign bus_data3 = bus_read3 ? mw3 : 32'bz;

  always @(posedge clk) begin
    if (bus_write1) begin
      mem1[a1]         <= bus_data1[7:0];
      mem1[a1 + 12'd1] <= bus_data1[15:8];
      mem1[a1 + 12'd2] <= bus_data1[23:16];
      mem1[a1 + 12'd3] <= bus_data1[31:24];
    end
    if (bd_we && !bd_sel) mem1[bd_addr] <= bd_byte;
  end

  always @(posedge clk) begin
    if (bus_write3) begin
      mem3[a3]         <= bus_data3[7:0];
      mem3[a3 + 12'd1] <= bus_data3[15:8];
      mem3[a3 + 12'd2] <= bus_data3[23:16];
      mem3[a3 + 12'd3] <= bus_data3[31:24];
    end
    if (bd_we && bd_sel) mem3[bd_addr] <= bd_byte;
  end

  // Observation mux onto whichever instance the current transaction targets.
  logic sel = 1'b0;
  wire        o_valid = sel ? rsp_valid3 : rsp_valid1;
  wire        o_err   = sel ? rsp_err3   : rsp_err1;
  wire [31:0] o_rdata = sel ? rsp_rdata3 : rsp_rdata1;
  wire        o_read  = sel ? bus_read3  : bus_read1;
  wire        o_write = sel ? bus_write3 : bus_write1;
  wire        o_ready = sel ? req_ready3 : req_ready1;
  wire [31:0] o_addr  = sel ? bus_addr3  : bus_addr1;
  wire [31:0] o_bus   = sel ? bus_data3  : bus_data1;
  wire [31:0] o_mw    = sel ? mw3        : mw1;

  int n_vec = 0;
  int n_err = 0;

  // Results of the most recent transaction.
  logic [31:0] r_rdata, r_hold, r_wdat;
  logic        r_err, r_bad, r_wstable, r_repeat, r_ready_after;
  int          r_lat, r_nrd, r_nwr;

  task automatic poke(input logic s, input logic [11:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bd_sel  = s;
      bd_addr = a + 12'(i);
      bd_byte = w[8*i +: 8];
      bd_we   = 1'b1;
    end
    @(negedge clk);
    bd_we = 1'b0;
  endtask

  // One request; r_lat = k means rsp_valid was high in the cycle after E(k).
  task automatic xact(input logic s, input logic wr, input logic [1:0] sz, input logic uns,
                      input logic [31:0] ad, input logic [31:0] wd);
    int   k;
    logic found, prev_w;
    sel = s;
    r_rdata = 32'd0; r_err = 1'b0; r_lat = -1; r_nrd = 0; r_nwr = 0; r_bad = 1'b0;
    r_hold = 32'd0; r_wdat = 32'd0; r_wstable = 1'b1; r_repeat = 1'b0; r_ready_after = 1'b0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = ad; req_wdata = wd;
    if (s) req_valid3 = 1'b1; else req_valid1 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    k = 0; found = 1'b0; prev_w = 1'b0;
    while (!found && k < 40) begin
      if (o_valid) begin
        found = 1'b1; r_lat = k; r_rdata = o_rdata; r_err = o_err;
      end else begin
        if (o_read && o_write) r_bad = 1'b1;
        if ((o_read || o_write) && o_addr !== ad) r_bad = 1'b1;
        if (o_read && o_bus !== o_mw) r_bad = 1'b1;
        if (o_read) r_nrd++;
        if (o_write) begin
          if (r_nwr > 0 && o_bus !== r_wdat) r_wstable = 1'b0;
          r_wdat = o_bus;
          r_nwr++;
        end
        if (prev_w && !o_write) r_hold = o_bus;
        prev_w = o_write;
        @(negedge clk);
        k++;
      end
    end
    @(negedge clk);
    r_repeat = o_valid;
    r_ready_after = o_ready;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_vec++; if (req_ready1 !== 1'b1) begin n_err++; $display("FAIL rst_ready: got %b want 1", req_ready1); end
    n_vec++; if (rsp_valid1 !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid1); end
    n_vec++; if (rsp_rdata1 !== 32'd0) begin n_err++; $display("FAIL rst_rdata: got %h want 0", rsp_rdata1); end
    n_vec++; if (rsp_err1 !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", rsp_err1); end
    n_vec++; if ({bus_read1, bus_write1, bus_read3, bus_write3} !== 4'b0) begin n_err++; $display("FAIL rst_strobes: got %b want 0000", {bus_read1, bus_write1, bus_read3, bus_write3}); end
    n_vec++; if (bus_addr1 !== 32'd0) begin n_err++; $display("FAIL rst_addr: got %h want 0", bus_addr1); end
    n_vec++; if (req_ready3 !== 1'b1) begin n_err++; $display("FAIL rst_ready3: got %b want 1", req_ready3); end
    rst = 1'b0;
    $display("reset released");
  endtask

  task automatic test_word_load();
    poke(1'b0, 12'h100, 32'h84332211);
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    $display("LW 0x100 -> %h lat %0d rd %0d wr %0d", r_rdata, r_lat, r_nrd, r_nwr);
    n_vec++; if (r_rdata !== 32'h84332211) begin n_err++; $display("FAIL lw_data: got %h want 84332211", r_rdata); end
    n_vec++; if (r_lat !== 2) begin n_err++; $display("FAIL lw_latency: got %0d want 2", r_lat); end
    n_vec++; if (r_nrd !== 1 || r_nwr !== 0) begin n_err++; $display("FAIL lw_strobes: got rd %0d wr %0d want 1/0", r_nrd, r_nwr); end
    n_vec++; if (r_err !== 1'b0 || r_bad !== 1'b0) begin n_err++; $display("FAIL lw_err_bus: got err %b bad %b want 0/0", r_err, r_bad); end
    n_vec++; if (r_repeat !== 1'b0 || r_ready_after !== 1'b1) begin n_err++; $display("FAIL lw_pulse: got repeat %b ready %b want 0/1", r_repeat, r_ready_after); end
  endtask

  task automatic test_signed_loads();
    logic [1:0]  szs  [4] = '{2'd0, 2'd0, 2'd1, 2'd1};
    logic        unss [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [31:0] ads  [4] = '{32'h205, 32'h205, 32'h204, 32'h204};
    logic [31:0] exps [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF8011, 32'h00008011};
    poke(1'b0, 12'h204, 32'h00008011);
    for (int i = 0; i < 4; i++) begin
      xact(1'b0, 1'b0, szs[i], unss[i], ads[i], 32'd0);
      $display("L size %0d uns %b @%h -> %h", szs[i], unss[i], ads[i], r_rdata);
      n_vec++; if (r_rdata !== exps[i]) begin n_err++; $display("FAIL ext_data[%0d]: got %h want %h", i, r_rdata, exps[i]); end
      n_vec++; if (r_lat !== 2 || r_err !== 1'b0) begin n_err++; $display("FAIL ext_lat[%0d]: got lat %0d err %b want 2/0", i, r_lat, r_err); end
    end
  endtask

  task automatic test_rmw();
    poke(1'b0, 12'h300, 32'hDDCCBBAA);
    xact(1'b0, 1'b1, 2'd1, 1'b0, 32'h300, 32'hAAAA1234);
    $display("SH 0x300 lat %0d rd %0d wr %0d wdata %h", r_lat, r_nrd, r_nwr, r_wdat);
    n_vec++; if (r_lat !== 6) begin n_err++; $display("FAIL sh_latency: got %0d want 6", r_lat); end
    n_vec++; if (r_nrd !== 1 || r_nwr !== 1) begin n_err++; $display("FAIL sh_strobes: got rd %0d wr %0d want 1/1", r_nrd, r_nwr); end
    n_vec++; if (r_wdat !== 32'hDDCC1234) begin n_err++; $display("FAIL sh_merge: got %h want DDCC1234", r_wdat); end
    n_vec++; if (r_bad !== 1'b0) begin n_err++; $display("FAIL sh_bus_rules: got bad %b want 0", r_bad); end
    n_vec++; if (r_rdata !== 32'd0 || r_err !== 1'b0) begin n_err++; $display("FAIL sh_rsp: got %h err %b want 0/0", r_rdata, r_err); end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
    $display("LW 0x300 -> %h", r_rdata);
    n_vec++; if (r_rdata !== 32'hDDCC1234) begin n_err++; $display("FAIL sh_readback: got %h want DDCC1234", r_rdata); end
    xact(1'b0, 1'b1, 2'd0, 1'b0, 32'h301, 32'h00000055);
    $display("SB 0x301 lat %0d", r_lat);
    n_vec++; if (r_lat !== 6) begin n_err++; $display("FAIL sb_latency: got %0d want 6", r_lat); end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h300, 32'd0);
    $display("LW 0x300 -> %h", r_rdata);
    n_vec++; if (r_rdata !== 32'hDDCC5534) begin n_err++; $display("FAIL sb_readback: got %h want DDCC5534", r_rdata); end
  endtask

  task automatic test_errors();
    logic        wrs [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  szs [3] = '{2'd2, 2'd1, 2'd3};
    logic [31:0] ads [3] = '{32'h102, 32'h101, 32'h100};
    for (int i = 0; i < 3; i++) begin
      xact(1'b0, wrs[i], szs[i], 1'b0, ads[i], 32'hFFFFFFFF);
      $display("ERR case %0d: err %b lat %0d rd %0d wr %0d", i, r_err, r_lat, r_nrd, r_nwr);
      n_vec++; if (r_err !== 1'b1 || r_lat !== 0) begin n_err++; $display("FAIL err_rsp[%0d]: got err %b lat %0d want 1/0", i, r_err, r_lat); end
      n_vec++; if (r_nrd !== 0 || r_nwr !== 0 || r_rdata !== 32'd0) begin n_err++; $display("FAIL err_quiet[%0d]: got rd %0d wr %0d data %h want 0/0/0", i, r_nrd, r_nwr, r_rdata); end
    end
    xact(1'b0, 1'b0, 2'd2, 1'b0, 32'h100, 32'd0);
    $display("LW 0x100 after errors -> %h", r_rdata);
    n_vec++; if (r_rdata !== 32'h84332211) begin n_err++; $display("FAIL err_mem_unchanged: got %h want 84332211", r_rdata); end
  endtask

  task automatic test_stretched();
    xact(1'b1, 1'b1, 2'd2, 1'b0, 32'h40, 32'hCAFEF00D);
    $display("SW3 0x40 lat %0d wr %0d hold %h", r_lat, r_nwr, r_hold);
    n_vec++; if (r_lat !== 5) begin n_err++; $display("FAIL sw3_latency: got %0d want 5", r_lat); end
    n_vec++; if (r_nwr !== 3 || r_nrd !== 0) begin n_err++; $display("FAIL sw3_strobes: got wr %0d rd %0d want 3/0", r_nwr, r_nrd); end
    n_vec++; if (r_wstable !== 1'b1 || r_wdat !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw3_data: got %h stable %b want CAFEF00D/1", r_wdat, r_wstable); end
    n_vec++; if (r_hold !== 32'hCAFEF00D) begin n_err++; $display("FAIL sw3_hold: got %h want CAFEF00D", r_hold); end
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    $display("LW3 0x40 -> %h lat %0d", r_rdata, r_lat);
    n_vec++; if (r_rdata !== 32'hCAFEF00D || r_lat !== 4 || r_nrd !== 3) begin n_err++; $display("FAIL lw3: got %h lat %0d rd %0d want CAFEF00D/4/3", r_rdata, r_lat, r_nrd); end
    xact(1'b1, 1'b1, 2'd0, 1'b0, 32'h40, 32'h00000011);
    $display("SB3 0x40 lat %0d", r_lat);
    n_vec++; if (r_lat !== 10) begin n_err++; $display("FAIL sb3_latency: got %0d want 10", r_lat); end
    xact(1'b1, 1'b0, 2'd2, 1'b0, 32'h40, 32'd0);
    $display("LW3 0x40 -> %h", r_rdata);
    n_vec++; if (r_rdata !== 32'hCAFEF011) begin n_err++; $display("FAIL sb3_readback: got %h want CAFEF011", r_rdata); end
  endtask

  task automatic test_back_to_back();
    logic [8:0]  vmask, rmask;
    logic [31:0] data2;
    sel = 1'b0;
    vmask = '0; rmask = '0; data2 = 32'd0;
    @(negedge clk);
    req_write = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h100; req_valid1 = 1'b1;
    @(posedge clk);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (k == 4) req_valid1 = 1'b0;
      vmask[k] = rsp_valid1;
      rmask[k] = req_ready1;
      if (k == 6) data2 = rsp_rdata1;
    end
    $display("B2B rsp mask %b ready mask %b data %h", vmask, rmask, data2);
    n_vec++; if (vmask !== 9'h044) begin n_err++; $display("FAIL b2b_rsp_mask: got %b want 001000100", vmask); end
    n_vec++; if (rmask !== 9'h188) begin n_err++; $display("FAIL b2b_ready_mask: got %b want 110001000", rmask); end
    n_vec++; if (data2 !== 32'h84332211) begin n_err++; $display("FAIL b2b_data: got %h want 84332211", data2); end
  endtask

  task automatic test_reset_mid_access();
    logic seen;
    sel = 1'b1;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'd2; req_addr = 32'h80; req_wdata = 32'h01234567; req_valid3 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid3 = 1'b0;
    @(negedge clk);
    n_vec++; if (bus_write3 !== 1'b1) begin n_err++; $display("FAIL rstmid_in_strobe: got %b want 1", bus_write3); end
    #2 rst = 1'b1;
    #1;
    n_vec++; if (bus_write3 !== 1'b0 || rsp_valid3 !== 1'b0) begin n_err++; $display("FAIL rstmid_async: got wr %b rsp %b want 0/0", bus_write3, rsp_valid3); end
    n_vec++; if (req_ready3 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready: got %b want 1", req_ready3); end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (rsp_valid3 || bus_write3) seen = 1'b1;
    end
    $display("reset mid-access: activity after release %b ready %b", seen, req_ready3);
    n_vec++; if (seen !== 1'b0) begin n_err++; $display("FAIL rstmid_no_rsp: got %b want 0", seen); end
    n_vec++; if (req_ready3 !== 1'b1) begin n_err++; $display("FAIL rstmid_ready_after: got %b want 1", req_ready3); end
  endtask

  initial begin
    test_reset();
    test_word_load();
    test_signed_loads();
    test_rmw();
    test_errors();
    test_stretched();
    test_back_to_back();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bus_initiator.md
# bus_initiator

Memory-bus initiator between the `rv` core and the byte-addressed `mem` responder. It turns single load/store requests (byte, half, word; signed or unsigned loads) into `addr`/`bus`/`read`/`write` sequences on the shared tri-state bus and returns one response per request. `mem` always transfers 4 bytes, so sub-word stores run as read-modify-write.

## Interface
Parameters:
- `STROBE_CYCLES`, 1: cycles that `bus_read`/`bus_write` are held high per access, minimum 1.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst`  in  1  reset, asynchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  block can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_size`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- `req_unsigned`  in  1  zero-extend the load result; ignored for stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, low-lane justified.
- `rsp_valid`  out  1  one-cycle response pulse.
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors.
- `rsp_err`  out  1  misaligned or illegal-size request.
- `bus_addr`  out  32  address to `mem`.
- `bus_data`  inout  32  shared data bus.
- `bus_read`  out  1  read strobe.
- `bus_write`  out  1  write strobe.

## Operation
- **FSM states:** IDLE, RD_SETUP, RD_STROBE, MERGE, WR_SETUP, WR_STROBE, WR_HOLD, RESP, ERR.
- **IDLE:**
  - `req_ready`=1 only in this state.
  - `req_valid` high captures all request fields.
- **Error check:** size 3, half with `addr[0]`=1, or word with `addr[1:0]`≠0 → ERR. No bus activity.
- **Next state after a legal request:**
  - load → RD_SETUP
  - word store → WR_SETUP
  - byte/half store → RD_SETUP
- **RD_SETUP:** `bus_addr` driven, both strobes 0.
- **RD_STROBE:**
  - `bus_read`=1 for `STROBE_CYCLES` cycles.
  - `bus_data` is sampled at the posedge that ends the last strobe cycle.
  - Then: load → RESP; sub-word store → MERGE.
- **MERGE:**
  - Replace the low 8 bits (byte) or low 16 bits (half) of the sampled word with `req_wdata`.
  - Upper lanes keep the read value.
- **WR_SETUP:** `bus_data` driven, `bus_write`=0.
- **WR_STROBE:** `bus_write`=1 for `STROBE_CYCLES` cycles.
- **WR_HOLD:** data still driven, `bus_write`=0 (hold time).
- **RESP / ERR:** `rsp_valid`=1 for one cycle, then IDLE. ERR also sets `rsp_err`=1.
- **Load extension:**
  - byte: `{24{d[7]}}`, d[7:0]; zero-filled if `req_unsigned`.
  - half: same rule using d[15].
  - word: passed through.
- **Bus drive rules:**
  - `bus_data` is high-Z except in MERGE→WR_SETUP, WR_STROBE and WR_HOLD.
  - Never driven while `bus_read`=1.
  - `bus_read` and `bus_write` are never high together.
- **Address stability:** `bus_addr` holds the request address from setup through the last strobe/hold cycle. It keeps its last value in IDLE.
- **No backpressure on responses:** a `rsp_valid` pulse is not repeated.

## Timing
- **Reset values (asynchronous, immediate):** `bus_read`=0, `bus_write`=0, `bus_addr`=0, `bus_data`=Z, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, state IDLE.
- **Reset mid-access:** the strobe drops asynchronously, the request is discarded and no response is issued.
- **Latency** (S=`STROBE_CYCLES`, request accepted at edge E0, `rsp_valid` high in the cycle after the stated edge):
  - load: after E(S+1)
  - word store: after E(S+2)
  - sub-word store: after E(2S+4)
  - error: after E0, i.e. the cycle following acceptance
- **Back-to-back:** the next request is accepted at the earliest one cycle after RESP, when IDLE is re-entered.

## Structure
- Package `bus_pkg`:
  - `size_t` enum: `SZ_B`=0, `SZ_H`=1, `SZ_W`=2.
  - `state_t` FSM enum.
  - `misaligned(size, addr)` function.
- Sub-module `bus_lane`, combinational: load extension and store lane merge. Shared by RD capture and MERGE.
- Tri-state driver in the top only.

## Test plan
- **Word load:** `mem`[0x100..0x103]=0x11,0x22,0x33,0x84; LW 0x100, S=1 → `bus_read` high exactly one cycle; `rsp_rdata`=0x84332211 at E2.
- **Signed/unsigned byte:** byte 0x80 at 0x205; LB 0x205 → 0xFFFFFF80; LBU 0x205 → 0x00000080.
- **Sub-word store (RMW):** `mem`[0x300..]=0xDDCCBBAA; SH 0x300 wdata 0x1234 → following LW 0x300 returns 0xDDCC1234.
  - Check one read strobe and then one write strobe.
  - Check `bus_data` is Z during the read.
- **Errors:** SW 0x102, LH 0x101 and size 3 → `rsp_err`=1 one cycle after acceptance, no strobes, `mem` unchanged.
- **Stretched strobe:** S=3 word store 0xCAFEF00D at 0x40 → `bus_write` high 3 cycles, data stable through WR_HOLD, `rsp_valid` at E5; readback matches.
- **Reset during access:** assert `rst` in WR_STROBE → `bus_write` low in the same cycle, no `rsp_valid`, `req_ready`=1 after release.
